// File: rtl/uart_rx_out_fifo.sv
// ============================================================================
// uart_rx_out_fifo : first-word-fall-through output queue for a UART receiver.
// Optional macro UART_RX_FIFO_ERR_TAG_EN stores a frame-error tag per entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          shift_reg_data_i,
  input  logic                       load_i,
  input  logic                       frame_err_i,
  input  logic                       data_ready_i,
  input  logic                       clear_overrun_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       data_o_valid,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overrun_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               overrun;

  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign full  = (level == LVL_DEPTH);
  assign empty = (level == '0);

  // A same-cycle pop frees the slot, so a push into a full queue is still accepted.
  assign pop  = !empty && data_ready_i;
  assign push = load_i && (!full || pop);
  assign drop = load_i && full && !pop;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign wr_entry = {frame_err_i, shift_reg_data_i};
`else
  assign wr_entry = shift_reg_data_i;
  logic unused_frame_err;
  assign unused_frame_err = frame_err_i;
`endif

  // Storage is not reset; empty gating keeps stale contents off the outputs.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun_i) begin
        overrun <= 1'b0;
      end
    end
  end

  assign head_entry = mem[rd_ptr];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    if (!empty) begin
      data_o = head_entry[DATA_W-1:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
      err_o  = head_entry[DATA_W];
`endif
    end
  end

  assign data_o_valid = !empty;
  assign level_o      = level;
  assign full_o       = full;
  assign empty_o      = empty;
  assign overrun_o    = overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_out_fifo.sv
// ============================================================================
// tb_uart_rx_out_fifo : directed self-checking bench for uart_rx_out_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_out_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam logic TAG_EN = 1'b1;
`else
  localparam logic TAG_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [DATA_W-1:0] shift_reg_data_i;
  logic              load_i;
  logic              frame_err_i;
  logic              data_ready_i;
  logic              clear_overrun_i;
  logic [DATA_W-1:0] data_o;
  logic              data_o_valid;
  logic              err_o;
  logic [2:0]        level_o;
  logic              full_o;
  logic              empty_o;
  logic              overrun_o;

  int checks = 0;
  int errors = 0;

  uart_rx_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .shift_reg_data_i (shift_reg_data_i),
    .load_i           (load_i),
    .frame_err_i      (frame_err_i),
    .data_ready_i     (data_ready_i),
    .clear_overrun_i  (clear_overrun_i),
    .data_o           (data_o),
    .data_o_valid     (data_o_valid),
    .err_o            (err_o),
    .level_o          (level_o),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .overrun_o        (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic e);
    load_i = 1'b1; shift_reg_data_i = d; frame_err_i = e;
    step();
    load_i = 1'b0; frame_err_i = 1'b0;
  endtask

  task automatic pop();
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(level_o), 32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"},  32'(full_o),  32'd0);
    check({tag, "_valid"}, 32'(data_o_valid), 32'd0);
    check({tag, "_data"},  32'(data_o),  32'd0);
    check({tag, "_err"},   32'(err_o),   32'd0);
    check({tag, "_ovr"},   32'(overrun_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; shift_reg_data_i = '0; load_i = 1'b0; frame_err_i = 1'b0;
    data_ready_i = 1'b0; clear_overrun_i = 1'b0;
    #3;
    check_reset_outputs("rst");
    step();
    rst_i = 1'b0;

    // Single word: no bypass before the edge, visible after it.
    load_i = 1'b1; shift_reg_data_i = 8'h41;
    #1;
    check("nobypass_valid", 32'(data_o_valid), 32'd0);
    step();
    load_i = 1'b0;
    check("p41_data",  32'(data_o), 32'h41);
    check("p41_valid", 32'(data_o_valid), 32'd1);
    check("p41_level", 32'(level_o), 32'd1);
    pop();
    check("pop41_empty", 32'(empty_o), 32'd1);
    check("pop41_data",  32'(data_o), 32'd0);

    // Fill, overflow, drain in order.
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    check("fill_full",  32'(full_o), 32'd1);
    check("fill_level", 32'(level_o), 32'd4);
    check("fill_ovr0",  32'(overrun_o), 32'd0);
    push(8'h05, 1'b0);
    check("drop_ovr",   32'(overrun_o), 32'd1);
    check("drop_level", 32'(level_o), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 32'(data_o), 32'(i));
      pop();
    end
    check("drain_empty", 32'(empty_o), 32'd1);
    check("drain_ovr_sticky", 32'(overrun_o), 32'd1);
    clear_overrun_i = 1'b1; step(); clear_overrun_i = 1'b0;
    check("clr_ovr", 32'(overrun_o), 32'd0);

    // Ready while empty is ignored.
    pop();
    check("empty_pop_level", 32'(level_o), 32'd0);
    check("empty_pop_empty", 32'(empty_o), 32'd1);

    // Push and pop together while full: no drop, new word ends up last.
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    load_i = 1'b1; shift_reg_data_i = 8'h10; data_ready_i = 1'b1;
    step();
    load_i = 1'b0; data_ready_i = 1'b0;
    check("pp_full_level", 32'(level_o), 32'd4);
    check("pp_full_ovr",   32'(overrun_o), 32'd0);
    check("pp_full_head",  32'(data_o), 32'h02);

    // Drop and clear in the same cycle: set wins.
    load_i = 1'b1; shift_reg_data_i = 8'h77; clear_overrun_i = 1'b1;
    step();
    load_i = 1'b0; clear_overrun_i = 1'b0;
    check("setwins_ovr", 32'(overrun_o), 32'd1);
    check("setwins_level", 32'(level_o), 32'd4);
    check("q_02", 32'(data_o), 32'h02); pop();
    check("q_03", 32'(data_o), 32'h03); pop();
    check("q_04", 32'(data_o), 32'h04); pop();
    check("q_10", 32'(data_o), 32'h10); pop();
    check("q_empty", 32'(empty_o), 32'd1);
    clear_overrun_i = 1'b1; step(); clear_overrun_i = 1'b0;

    // Equal consecutive words are both queued.
    push(8'h55, 1'b0); push(8'h55, 1'b0);
    check("dup_level", 32'(level_o), 32'd2);
    check("dup_first", 32'(data_o), 32'h55); pop();
    check("dup_second", 32'(data_o), 32'h55);
    check("dup_level1", 32'(level_o), 32'd1);

    // Push and pop together at level 1.
    load_i = 1'b1; shift_reg_data_i = 8'hA1; data_ready_i = 1'b1;
    step();
    load_i = 1'b0; data_ready_i = 1'b0;
    check("pp1_level", 32'(level_o), 32'd1);
    check("pp1_data",  32'(data_o), 32'hA1);
    pop();

    // Frame-error tag follows the head word.
    push(8'h33, 1'b1); push(8'h34, 1'b0);
    check("tag_33_data", 32'(data_o), 32'h33);
    check("tag_33_err",  32'(err_o), 32'(TAG_EN));
    pop();
    check("tag_34_data", 32'(data_o), 32'h34);
    check("tag_34_err",  32'(err_o), 32'd0);
    pop();

    // Asynchronous reset mid-cycle with three words stored.
    push(8'hC1, 1'b1); push(8'hC2, 1'b0); push(8'hC3, 1'b1);
    check("pre_rst_level", 32'(level_o), 32'd3);
    #3;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("arst");
    step();
    rst_i = 1'b0;
    push(8'h99, 1'b0);
    check("post_rst_level", 32'(level_o), 32'd1);
    check("post_rst_data",  32'(data_o), 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
